// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Schedules the shared multiply/divide units (MULT, MULTU, DIV, DIVU) on
// behalf of the multicycle controller. An accepted operation has its operands
// latched. The sequencer then fires a one-cycle start into the selected unit,
// waits for that unit to finish, and writes HI/LO in a single cycle. The
// controller is stalled (md_busy) for the whole sequence.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   op_valid, op_sel[1:0]        request and opcode (00 MULT, 01 MULTU,
//                                10 DIV, 11 DIVU)
//   rs_value, rt_value [31:0]    operands, captured on accept
//   abort                        cancel current operation (exception/eret)
//   op_ready, md_busy            idle indication / controller stall
//   unit_a, unit_b [31:0]        latched operands fanned out to all units
//   mul_start .. divu_start      one-cycle start pulses, one per unit
//   mul_done, mulu_done          multiplier completion pulses
//   div_busy, divu_busy          divider busy levels
//   mul_z, mulu_z [63:0]         multiplier products
//   div_q/div_r, divu_q/divu_r   divider quotient / remainder
//   hi_wdata, lo_wdata [31:0]    HI/LO write data (hold last written value)
//   hi_ena, lo_ena               HI/LO write enables
//   op_done                      pulse on the HI/LO write cycle
//   op_err                       pulse when the completion timeout fires
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_sel,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic        abort,
  output logic        op_ready,
  output logic        md_busy,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mul_start,
  output logic        mulu_start,
  output logic        div_start,
  output logic        divu_start,
  input  logic        mul_done,
  input  logic        mulu_done,
  input  logic        div_busy,
  input  logic        divu_busy,
  input  logic [63:0] mul_z,
  input  logic [63:0] mulu_z,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [31:0] divu_q,
  input  logic [31:0] divu_r,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        hi_ena,
  output logic        lo_ena,
  output logic        op_done,
  output logic        op_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // The counter is cleared in ISSUE and counts WAIT/DRAIN cycles; the
  // timeout fires in the cycle where it would step to TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic [31:0]       a_reg, a_next;
  logic [31:0]       b_reg, b_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              seen_busy_reg, seen_busy_next;
  logic [31:0]       res_hi_reg, res_hi_next;
  logic [31:0]       res_lo_reg, res_lo_next;

  logic              is_div;
  logic              unit_busy;
  logic              unit_done;
  logic              complete;
  logic              timeout_hit;
  logic              issue_fire;
  logic              write_fire;
  logic              err_fire;
  logic [31:0]       result_hi;
  logic [31:0]       result_lo;
  logic [3:0]        start_vec;

  // ---------------------------------------------------------------------
  // Completion detection for the unit selected by the latched opcode.
  // Multipliers signal with a done pulse. Dividers only expose a busy
  // level, so completion is the first low sample after busy was seen
  // high; this ignores the low level before the divider picks up its start.
  // ---------------------------------------------------------------------
  assign is_div      = op_reg[1];
  assign unit_busy   = op_reg[0] ? divu_busy : div_busy;
  assign unit_done   = op_reg[0] ? mulu_done : mul_done;
  assign complete    = is_div ? (seen_busy_reg && !unit_busy) : unit_done;
  assign timeout_hit = (cnt_reg == CNT_LAST);

  always_comb begin
    result_hi = 32'd0;
    result_lo = 32'd0;
    case (op_reg)
      2'b00: begin
        result_hi = mul_z[63:32];
        result_lo = mul_z[31:0];
      end
      2'b01: begin
        result_hi = mulu_z[63:32];
        result_lo = mulu_z[31:0];
      end
      2'b10: begin
        result_hi = div_r;
        result_lo = div_q;
      end
      default: begin
        result_hi = divu_r;
        result_lo = divu_q;
      end
    endcase
  end

  // Start pulses: one per unit, only in ISSUE and only if not aborted.
  assign issue_fire = (state_reg == ST_ISSUE) && !abort;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_start
      assign start_vec[gi] = issue_fire && (op_reg == 2'(gi));
    end
  endgenerate

  assign mul_start  = start_vec[0];
  assign mulu_start = start_vec[1];
  assign div_start  = start_vec[2];
  assign divu_start = start_vec[3];

  // HI/LO write happens only in WRITE; an abort there cancels it.
  assign write_fire = (state_reg == ST_WRITE) && !abort;
  assign hi_ena     = write_fire;
  assign lo_ena     = write_fire;
  assign op_done    = write_fire;
  assign op_err     = err_fire;

  // The result registers only change on entry to WRITE, so they double as
  // the write data that holds its value outside the write cycle.
  assign hi_wdata   = res_hi_reg;
  assign lo_wdata   = res_lo_reg;

  assign op_ready   = (state_reg == ST_IDLE);
  assign md_busy    = !op_ready;
  assign unit_a     = a_reg;
  assign unit_b     = b_reg;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= 2'b00;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      cnt_reg       <= '0;
      seen_busy_reg <= 1'b0;
      res_hi_reg    <= 32'd0;
      res_lo_reg    <= 32'd0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      cnt_reg       <= cnt_next;
      seen_busy_reg <= seen_busy_next;
      res_hi_reg    <= res_hi_next;
      res_lo_reg    <= res_lo_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    cnt_next       = cnt_reg;
    seen_busy_next = seen_busy_reg;
    res_hi_next    = res_hi_reg;
    res_lo_next    = res_lo_reg;
    err_fire       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // An abort in IDLE also blocks acceptance for that cycle.
        if (op_valid && !abort) begin
          op_next = op_sel;
          a_next  = rs_value;
          b_next  = rt_value;
          if (op_sel[1] && (rt_value == 32'd0)) begin
            // Divide by zero: the dividers are never started; the
            // architected result is HI=dividend, LO=all ones.
            res_hi_next = rs_value;
            res_lo_next = 32'hFFFF_FFFF;
            state_next  = ST_WRITE;
          end else begin
            state_next  = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        cnt_next       = '0;
        seen_busy_next = 1'b0;
        state_next     = abort ? ST_IDLE : ST_WAIT;
      end

      ST_WAIT: begin
        cnt_next       = cnt_reg + 1'b1;
        seen_busy_next = seen_busy_reg | unit_busy;
        if (abort) begin
          // If the unit finishes (or times out) in the same cycle there is
          // nothing left to drain.
          state_next = (complete || timeout_hit) ? ST_IDLE : ST_DRAIN;
        end else if (complete) begin
          res_hi_next = result_hi;
          res_lo_next = result_lo;
          state_next  = ST_WRITE;
        end else if (timeout_hit) begin
          err_fire   = 1'b1;
          state_next = ST_IDLE;
        end
      end

      ST_WRITE: begin
        state_next = ST_IDLE;
      end

      ST_DRAIN: begin
        // Keep the controller stalled until the cancelled unit is quiet so
        // it is never restarted mid-computation. The timeout budget carries
        // over from WAIT.
        cnt_next       = cnt_reg + 1'b1;
        seen_busy_next = seen_busy_reg | unit_busy;
        if (complete || timeout_hit) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
